// File: rtl/note_sequencer.sv
// note_sequencer: table-driven melody player feeding one audio_channel.
// Define SEQ_GAP_EN to silence the final GAP_CYCLES clocks of every note.
module note_sequencer #(
   parameter int DEPTH = 32,
   parameter int TICK_DIV = 3125000,
   parameter int GAP_CYCLES = 62500,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(TICK_DIV)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [31:0]   wr_data_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          loop_i,
   output logic          ch_en_o,
   output logic [2:0]    ch_gen_sel_o,
   output logic [15:0]   ch_freq_o,
   output logic [7:0]    ch_volume_o,
   output logic          busy_o,
   output logic          done_o,
   output logic [AW-1:0] note_idx_o
);
`ifdef SEQ_GAP_EN
   localparam int GAP = GAP_CYCLES;
`else
   localparam int GAP = 0;
`endif
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, LOAD = 3'd2, PLAY = 3'd3, DONE = 3'd4;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   rd_data;
   logic [2:0]    state;
   logic [AW-1:0] ptr;
   logic [3:0]    tick, dur;
   logic [CW-1:0] cyc;
   logic          last_cyc, last_tick, gap_start;
   assign last_cyc  = cyc == CW'(TICK_DIV - 1);
   assign last_tick = tick == dur - 4'd1;
   // the gap is latched into ch_en_o so it also covers the FETCH/LOAD hold
   assign gap_start = GAP > 0 && last_tick && cyc == CW'(TICK_DIV - GAP - 1);
   assign busy_o    = state != IDLE;
   assign done_o    = state == DONE;
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      rd_data <= mem[ptr];
   end
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state        <= IDLE;
         ptr          <= '0;
         tick         <= '0;
         dur          <= '0;
         cyc          <= '0;
         ch_en_o      <= 1'b0;
         ch_gen_sel_o <= '0;
         ch_freq_o    <= '0;
         ch_volume_o  <= '0;
         note_idx_o   <= '0;
      end else if (stop_i) begin
         state   <= IDLE;
         ch_en_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               state <= FETCH;
               ptr   <= '0;
            end
            FETCH: state <= LOAD;
            LOAD: if (rd_data[11:8] == 4'd0) begin
               // a marker at entry 0 always ends, so an empty table cannot spin
               if (loop_i && ptr != '0) begin
                  ptr   <= '0;
                  state <= FETCH;
               end else begin
                  ch_en_o <= 1'b0;
                  state   <= DONE;
               end
            end else begin
               ch_freq_o    <= rd_data[31:16];
               ch_gen_sel_o <= rd_data[15:13];
               ch_en_o      <= ~rd_data[12];
               dur          <= rd_data[11:8];
               ch_volume_o  <= rd_data[7:0];
               note_idx_o   <= ptr;
               tick         <= '0;
               cyc          <= '0;
               state        <= PLAY;
            end
            PLAY: begin
               if (gap_start) ch_en_o <= 1'b0;
               if (last_cyc) begin
                  cyc  <= '0;
                  tick <= tick + 4'd1;
                  if (last_tick) begin
                     ptr   <= ptr + AW'(1);
                     state <= FETCH;
                  end
               end else begin
                  cyc <= cyc + CW'(1);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer with TICK_DIV=10, GAP_CYCLES=3.
module tb_note_sequencer;
   localparam int TD = 10;
`ifdef SEQ_GAP_EN
   localparam int GAP = 3;
`else
   localparam int GAP = 0;
`endif
   logic clk = 0, rstn = 0, wr_en = 0, start = 0, stop = 0, loop = 0;
   logic [4:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic ch_en, busy, done;
   logic [2:0] gen;
   logic [15:0] freq;
   logic [7:0] vol;
   logic [4:0] idx;
   int errors = 0, checks = 0;
   note_sequencer #(.DEPTH(32), .TICK_DIV(TD), .GAP_CYCLES(3)) dut (
      .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .start_i(start), .stop_i(stop), .loop_i(loop), .ch_en_o(ch_en), .ch_gen_sel_o(gen),
      .ch_freq_o(freq), .ch_volume_o(vol), .busy_o(busy), .done_o(done), .note_idx_o(idx)
   );
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(int a, logic [31:0] d);
      wr_en = 1; wr_addr = 5'(a); wr_data = d;
      step();
      wr_en = 0;
   endtask
   function automatic logic [31:0] enc(int f, int s, int r, int d, int v);
      return {16'(f), 3'(s), 1'(r), 4'(d), 8'(v)};
   endfunction
   task automatic go();
      start = 1;
      step();
      start = 0;
      chk("busy_fetch", 32'(busy), 1);
      step();
      step();
   endtask
   task automatic check_note(int n, int f, int s, int v, int r, int d);
      chk("sel", 32'(gen), s);
      chk("vol", 32'(vol), v);
      for (int c = 0; c < TD * d + 2; c++) begin
         chk("freq", 32'(freq), f);
         chk("idx", 32'(idx), n);
         chk("no_done", 32'(done), 0);
         chk("busy", 32'(busy), 1);
         chk("en", 32'(ch_en),
             (r == 0 && (c < TD * d ? (GAP == 0 || c < TD * d - GAP) : GAP == 0)) ? 1 : 0);
         step();
      end
   endtask
   task automatic check_end();
      chk("done", 32'(done), 1);
      step();
      chk("done_clr", 32'(done), 0);
      chk("busy_clr", 32'(busy), 0);
      chk("en_off", 32'(ch_en), 0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", 32'(ch_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_freq", 32'(freq), 0);
      chk("rst_sel", 32'(gen), 0);
      chk("rst_vol", 32'(vol), 0);
      chk("rst_idx", 32'(idx), 0);
      rstn = 1;
      step();
      // single note, two ticks
      wr(0, enc(4208, 4, 0, 2, 255));
      wr(1, 0);
      go();
      check_note(0, 4208, 4, 255, 0, 2);
      check_end();
      // three notes, middle one a rest
      wr(0, enc(4208, 4, 0, 1, 255));
      wr(1, enc(3339, 2, 1, 1, 128));
      wr(2, enc(5005, 1, 0, 1, 64));
      wr(3, 0);
      go();
      check_note(0, 4208, 4, 255, 0, 1);
      check_note(1, 3339, 2, 128, 1, 1);
      check_note(2, 5005, 1, 64, 0, 1);
      check_end();
      // loop back once, then finish
      wr(1, enc(3339, 2, 0, 1, 128));
      wr(2, 0);
      loop = 1;
      go();
      check_note(0, 4208, 4, 255, 0, 1);
      check_note(1, 3339, 2, 128, 0, 1);
      chk("loop_fetch_done", 32'(done), 0);
      chk("loop_fetch_busy", 32'(busy), 1);
      step();
      chk("loop_load_done", 32'(done), 0);
      step();
      loop = 0;
      check_note(0, 4208, 4, 255, 0, 1);
      check_note(1, 3339, 2, 128, 0, 1);
      check_end();
      // abort mid-note of entry 1
      go();
      check_note(0, 4208, 4, 255, 0, 1);
      repeat (3) step();
      chk("abort_idx", 32'(idx), 1);
      chk("abort_en_pre", 32'(ch_en), 1);
      stop = 1;
      step();
      stop = 0;
      chk("abort_en", 32'(ch_en), 0);
      chk("abort_busy", 32'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_done", 32'(done), 0);
         step();
      end
      start = 1; stop = 1;
      step();
      start = 0; stop = 0;
      chk("startstop_busy", 32'(busy), 0);
      step();
      chk("startstop_busy2", 32'(busy), 0);
      // asynchronous reset mid-note
      go();
      repeat (3) step();
      chk("pre_rst_en", 32'(ch_en), 1);
      #2 rstn = 0;
      #1;
      chk("arst_en", 32'(ch_en), 0);
      chk("arst_freq", 32'(freq), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_sel", 32'(gen), 0);
      chk("arst_vol", 32'(vol), 0);
      chk("arst_idx", 32'(idx), 0);
      #3 rstn = 1;
      step();
      go();
      check_note(0, 4208, 4, 255, 0, 1);
      check_note(1, 3339, 2, 128, 0, 1);
      check_end();
      // repeated identical notes
      wr(1, enc(4208, 4, 0, 1, 255));
      go();
      check_note(0, 4208, 4, 255, 0, 1);
      check_note(1, 4208, 4, 255, 0, 1);
      check_end();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
